// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: store-data masking, misaligned-access squash, HALT drain tracking.
// Latency: one cycle from EX inputs to MEM outputs; o_halted rises three edges after HALT capture.
// Backpressure: i_stall holds every register; i_flush (over stall) or HALTED state loads a bubble.
//
// Ports: i_clk/i_reset (async, active-high); i_stall/i_flush slot control; i_valid + EX payload
// (i_alu_result, i_rt_data, i_rd_addr, mem/wb controls, i_BHW, i_halt); o_* registered MEM-side
// copies plus o_valid, o_misaligned and o_halted.
module ex_mem_reg #(
    parameter int NB_WIDTH = 32,
    parameter int NB_REG   = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [NB_WIDTH-1:0] i_alu_result,
    input  logic [NB_WIDTH-1:0] i_rt_data,
    input  logic [NB_REG-1:0]   i_rd_addr,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic [2:0]          i_BHW,
    input  logic                i_reg_write,
    input  logic                i_mem_to_reg,
    input  logic                i_halt,
    output logic [NB_WIDTH-1:0] o_mem_addr,
    output logic [NB_WIDTH-1:0] o_mem_data,
    output logic [NB_REG-1:0]   o_rd_addr,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic [2:0]          o_BHW,
    output logic                o_reg_write,
    output logic                o_mem_to_reg,
    output logic                o_valid,
    output logic                o_misaligned,
    output logic                o_halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;

    logic                take_halt;
    logic                mem_access;
    logic                misaligned;
    logic [NB_WIDTH-1:0] masked_data;

    // HALT is only accepted on a real capture edge.
    assign take_halt = i_valid & i_halt & ~i_stall & ~i_flush;

    // ---------------- Halt-drain FSM ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (take_halt) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = 2'd0;
                end
            end
            ST_DRAIN: begin
                // Counts every edge, stalled or not: the HALT needs two cycles to clear MEM and WB.
                cnt_nxt = cnt + 2'd1;
                if (cnt == 2'd1) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // ---------------- Capture-side datapath ----------------
    always_comb begin
        masked_data = i_rt_data;
        case (i_BHW[1:0])
            2'b00:   masked_data = {{(NB_WIDTH-8){1'b0}},  i_rt_data[7:0]};
            2'b01:   masked_data = {{(NB_WIDTH-16){1'b0}}, i_rt_data[15:0]};
            default: masked_data = i_rt_data;
        endcase
    end

    assign mem_access = (i_mem_read | i_mem_write) & i_valid;

    always_comb begin
        misaligned = 1'b0;
        if (mem_access) begin
            if (i_BHW[1:0] == 2'b01) begin
                misaligned = i_alu_result[0];
            end else if (i_BHW[1:0] == 2'b11) begin
                misaligned = (i_alu_result[1:0] != 2'b00);
            end
        end
    end

    // ---------------- Slot register ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            o_rd_addr    <= '0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_BHW        <= 3'b000;
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
            o_halted     <= 1'b0;
        end else begin
            o_halted <= (state == ST_HALTED);
            if ((state == ST_HALTED) || i_flush) begin
                o_mem_addr   <= '0;
                o_mem_data   <= '0;
                o_rd_addr    <= '0;
                o_mem_read   <= 1'b0;
                o_mem_write  <= 1'b0;
                o_BHW        <= 3'b000;
                o_reg_write  <= 1'b0;
                o_mem_to_reg <= 1'b0;
                o_valid      <= 1'b0;
                o_misaligned <= 1'b0;
            end else if (!i_stall) begin
                if (i_valid && i_halt) begin
                    // HALT travels as a bubble that still counts as a real slot.
                    o_mem_addr   <= '0;
                    o_mem_data   <= '0;
                    o_rd_addr    <= '0;
                    o_mem_read   <= 1'b0;
                    o_mem_write  <= 1'b0;
                    o_BHW        <= 3'b000;
                    o_reg_write  <= 1'b0;
                    o_mem_to_reg <= 1'b0;
                    o_valid      <= 1'b1;
                    o_misaligned <= 1'b0;
                end else begin
                    // Misaligned slots keep address/rd for debug but lose all side effects.
                    o_mem_addr   <= i_alu_result;
                    o_mem_data   <= masked_data;
                    o_rd_addr    <= i_rd_addr;
                    o_mem_read   <= i_mem_read  & ~misaligned;
                    o_mem_write  <= i_mem_write & ~misaligned;
                    o_BHW        <= i_BHW;
                    o_reg_write  <= i_reg_write & ~misaligned;
                    o_mem_to_reg <= i_mem_to_reg;
                    o_valid      <= i_valid;
                    o_misaligned <= misaligned;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stall = 1'b0, i_flush = 1'b0, i_valid = 1'b0;
    logic [31:0] i_alu_result = '0, i_rt_data = '0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic [2:0]  i_BHW = 3'b000;
    logic        i_reg_write = 1'b0, i_mem_to_reg = 1'b0, i_halt = 1'b0;
    logic [31:0] o_mem_addr, o_mem_data;
    logic [4:0]  o_rd_addr;
    logic        o_mem_read, o_mem_write;
    logic [2:0]  o_BHW;
    logic        o_reg_write, o_mem_to_reg, o_valid, o_misaligned, o_halted;

    ex_mem_reg #(.NB_WIDTH(32), .NB_REG(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_alu_result(i_alu_result), .i_rt_data(i_rt_data),
        .i_rd_addr(i_rd_addr), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_BHW(i_BHW), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
        .i_halt(i_halt), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_rd_addr(o_rd_addr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_BHW(o_BHW), .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
        .o_valid(o_valid), .o_misaligned(o_misaligned), .o_halted(o_halted)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // Reference model: expected MEM-side slot plus "edges since HALT was accepted".
    logic [31:0] e_addr, e_data;
    logic [4:0]  e_rd;
    logic        e_rd_en, e_wr_en, e_rw, e_m2r, e_valid, e_mis, e_halted;
    logic [2:0]  e_bhw;
    bit          m_active;
    int          m_age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_bubble(input logic v);
        e_addr = '0; e_data = '0; e_rd = '0; e_rd_en = 0; e_wr_en = 0; e_bhw = '0;
        e_rw = 0; e_m2r = 0; e_valid = v; e_mis = 0;
    endtask

    task automatic m_reset();
        m_bubble(1'b0);
        e_halted = 0;
        m_active = 0;
        m_age = 0;
    endtask

    // One rising edge as seen by the pipeline rules.
    task automatic m_edge();
        bit halted_now;
        bit access, mis;
        halted_now = m_active && (m_age >= 2);
        e_halted = halted_now;
        if (m_active && m_age < 3) m_age++;
        if (halted_now || i_flush) begin
            m_bubble(1'b0);
        end else if (!i_stall) begin
            if (i_valid && i_halt) begin
                m_bubble(1'b1);
                if (!m_active) begin
                    m_active = 1;
                    m_age = 0;
                end
            end else begin
                access = (i_mem_read || i_mem_write) && i_valid;
                mis = access && ((i_BHW[1:0] == 2'b01 && (i_alu_result % 2) != 0) ||
                                 (i_BHW[1:0] == 2'b11 && (i_alu_result % 4) != 0));
                e_addr = i_alu_result;
                if (i_BHW[1:0] == 2'b00)      e_data = i_rt_data % 256;
                else if (i_BHW[1:0] == 2'b01) e_data = i_rt_data % 65536;
                else                          e_data = i_rt_data;
                e_rd    = i_rd_addr;
                e_rd_en = i_mem_read && !mis;
                e_wr_en = i_mem_write && !mis;
                e_rw    = i_reg_write && !mis;
                e_m2r   = i_mem_to_reg;
                e_bhw   = i_BHW;
                e_valid = i_valid;
                e_mis   = mis;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},   o_mem_addr,   e_addr);
        chk({tag, ".data"},   o_mem_data,   e_data);
        chk({tag, ".rd"},     32'(o_rd_addr), 32'(e_rd));
        chk({tag, ".mrd"},    32'(o_mem_read), 32'(e_rd_en));
        chk({tag, ".mwr"},    32'(o_mem_write), 32'(e_wr_en));
        chk({tag, ".bhw"},    32'(o_BHW), 32'(e_bhw));
        chk({tag, ".rw"},     32'(o_reg_write), 32'(e_rw));
        chk({tag, ".m2r"},    32'(o_mem_to_reg), 32'(e_m2r));
        chk({tag, ".valid"},  32'(o_valid), 32'(e_valid));
        chk({tag, ".mis"},    32'(o_misaligned), 32'(e_mis));
        chk({tag, ".halted"}, 32'(o_halted), 32'(e_halted));
    endtask

    // Advance one edge, update the model, sample on the following falling edge.
    task automatic step(input string tag);
        @(posedge i_clk);
        if (!i_reset) m_edge();
        @(negedge i_clk);
        check_all(tag);
    endtask

    task automatic set_ins(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                           input logic [4:0] rd, input logic mr, input logic mw,
                           input logic [2:0] bhw, input logic rw, input logic m2r,
                           input logic halt);
        i_valid = v; i_alu_result = alu; i_rt_data = rt; i_rd_addr = rd;
        i_mem_read = mr; i_mem_write = mw; i_BHW = bhw; i_reg_write = rw;
        i_mem_to_reg = m2r; i_halt = halt;
    endtask

    task automatic idle_ins();
        set_ins(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        #2 i_reset = 1'b1;
        m_reset();
        #1 check_all({tag, ".async"});
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check_all({tag, ".held"});
    endtask

    logic [2:0] bhw_pick [8];

    initial begin
        bhw_pick = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111, 3'b010, 3'b110};
        m_reset();
        // Power-on reset
        repeat (2) @(negedge i_clk);
        check_all("por");
        i_reset = 1'b0;

        // Load something, then reset between edges
        set_ins(1, 32'h44, 32'h1234, 5'd3, 0, 1, 3'b011, 0, 0, 0);
        step("pre_rst");
        do_reset("rst");

        // LW at 0x10
        set_ins(1, 32'h10, 32'h0, 5'd7, 1, 0, 3'b011, 1, 1, 0);
        step("lw");
        chk("lw.mrd_const", 32'(o_mem_read), 32'd1);
        chk("lw.addr_const", o_mem_addr, 32'h10);
        chk("lw.bhw_const", 32'(o_BHW), 32'd3);

        // Store masking
        set_ins(1, 32'h40, 32'hAABBCCDD, 5'd0, 0, 1, 3'b000, 0, 0, 0);
        step("sb");
        chk("sb.data_const", o_mem_data, 32'h000000DD);
        i_BHW = 3'b001;
        step("sh");
        chk("sh.data_const", o_mem_data, 32'h0000CCDD);
        i_BHW = 3'b011;
        step("sw");
        chk("sw.data_const", o_mem_data, 32'hAABBCCDD);

        // Misalignment
        set_ins(1, 32'h21, 32'h0, 5'd9, 1, 0, 3'b001, 1, 1, 0);
        step("lh_mis");
        chk("lh_mis.mis_const", 32'(o_misaligned), 32'd1);
        chk("lh_mis.mrd_const", 32'(o_mem_read), 32'd0);
        chk("lh_mis.rw_const", 32'(o_reg_write), 32'd0);
        // Misaligned slot held by a stall keeps o_misaligned high
        i_stall = 1'b1;
        set_ins(1, 32'h100, 32'h0, 5'd1, 0, 0, 3'b011, 1, 0, 0);
        step("mis_hold");
        chk("mis_hold.mis_const", 32'(o_misaligned), 32'd1);
        i_stall = 1'b0;
        set_ins(1, 32'h22, 32'h5555, 5'd0, 0, 1, 3'b011, 0, 0, 0);
        step("sw_mis");
        chk("sw_mis.mwr_const", 32'(o_mem_write), 32'd0);
        set_ins(1, 32'h23, 32'h5555, 5'd0, 0, 1, 3'b000, 0, 0, 0);
        step("sb_ok");
        chk("sb_ok.mis_const", 32'(o_misaligned), 32'd0);
        chk("sb_ok.mwr_const", 32'(o_mem_write), 32'd1);

        // Stall holds an ADD with rd=5
        set_ins(1, 32'h77, 32'h0, 5'd5, 0, 0, 3'b011, 1, 0, 0);
        step("add");
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_ins(1, $urandom, $urandom, 5'($urandom_range(6, 31)), 1, 0, 3'b011, 1, 1, 0);
            step("stall");
            chk("stall.rd_const", 32'(o_rd_addr), 32'd5);
        end
        // Stall + flush gives a bubble
        i_flush = 1'b1;
        step("stall_flush");
        chk("stall_flush.valid_const", 32'(o_valid), 32'd0);
        i_stall = 1'b0;
        i_flush = 1'b0;

        // HALT drain
        set_ins(1, 32'h0, 32'h0, 5'd0, 0, 0, 3'b011, 0, 0, 1);
        step("halt_cap");
        chk("halt_cap.valid_const", 32'(o_valid), 32'd1);
        idle_ins();
        i_flush = 1'b1;                      // flush in DRAIN must not cancel
        step("drain1");
        i_flush = 1'b0;
        step("drain2");
        chk("drain2.halted_const", 32'(o_halted), 32'd0);
        step("drain3");
        chk("drain3.halted_const", 32'(o_halted), 32'd1);
        set_ins(1, 32'h80, 32'h9, 5'd2, 0, 1, 3'b011, 0, 0, 0);
        step("halted_sw");
        chk("halted_sw.mwr_const", 32'(o_mem_write), 32'd0);
        chk("halted_sw.halted_const", 32'(o_halted), 32'd1);
        do_reset("rst_after_halt");

        // Reset in the middle of a drain
        set_ins(1, 32'h0, 32'h0, 5'd0, 0, 0, 3'b011, 0, 0, 1);
        step("halt2_cap");
        idle_ins();
        step("halt2_d1");
        do_reset("rst_drain");
        set_ins(1, 32'h20, 32'h0, 5'd4, 1, 0, 3'b011, 1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step("post_rst");
            chk("post_rst.halted_const", 32'(o_halted), 32'd0);
            chk("post_rst.mrd_const", 32'(o_mem_read), 32'd1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd_rst");
            end else begin
                i_stall = ($urandom_range(0, 4) == 0);
                i_flush = ($urandom_range(0, 9) == 0);
                set_ins($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom),
                        1'($urandom), 1'($urandom), bhw_pick[$urandom_range(0, 7)],
                        1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0);
                step("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register placed directly upstream of the MEM stage. It captures the execute-stage result and the memory/writeback controls, then drives the MEM stage's address, store data, read/write enables and BHW code. The block also does three things on the way through: it masks store data by access size, detects misaligned accesses and squashes them into bubbles, and runs a halt-drain state machine that reports when a HALT instruction has fully retired.

## Interface
Parameters:
- NB_WIDTH, 32, datapath width
- NB_REG, 5, register-address width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_stall  in  1  hold all registered contents
- i_flush  in  1  load a bubble on the next edge
- i_valid  in  1  EX slot holds a real instruction
- i_alu_result  in  NB_WIDTH  effective address or ALU result
- i_rt_data  in  NB_WIDTH  store source data
- i_rd_addr  in  NB_REG  destination register
- i_mem_read  in  1  load enable
- i_mem_write  in  1  store enable
- i_BHW  in  3  access size code: 000 byte, 001 half, 011 word; bit2 = unsigned
- i_reg_write  in  1  writeback enable
- i_mem_to_reg  in  1  writeback source select
- i_halt  in  1  EX slot holds HALT
- o_mem_addr  out  NB_WIDTH  address to MEM
- o_mem_data  out  NB_WIDTH  store data to MEM
- o_rd_addr  out  NB_REG  forwarded destination register
- o_mem_read  out  1  load enable to MEM
- o_mem_write  out  1  store enable to MEM
- o_BHW  out  3  size code to MEM
- o_reg_write  out  1  writeback enable
- o_mem_to_reg  out  1  writeback source select
- o_valid  out  1  MEM slot is real
- o_misaligned  out  1  the captured instruction was squashed for misalignment
- o_halted  out  1  pipeline fully drained after HALT

## Operation
- **Capture.** On each edge, in priority order:
  - reset;
  - else HALTED state → load a bubble;
  - else i_flush → load a bubble (flush overrides stall);
  - else i_stall → hold all contents;
  - else load the inputs.
- **Bubble.** valid, mem_read, mem_write, reg_write, mem_to_reg, misaligned and halt-tag are all 0. addr, data, rd and BHW are 0.
- **Store data masking.** Applied on capture:
  - BHW[1:0]=00 → {24'b0, rt[7:0]};
  - BHW[1:0]=01 → {16'b0, rt[15:0]};
  - otherwise rt is passed through unchanged.
- **Misalignment.** Evaluated when (i_mem_read | i_mem_write) & i_valid:
  - half access (BHW[1:0]=01) with addr[0]=1 is misaligned;
  - word access (BHW[1:0]=11) with addr[1:0]≠00 is misaligned.
  - On a misaligned capture: mem_read, mem_write and reg_write are registered as 0, o_misaligned=1, o_valid=1, and address/rd are kept for debug.
  - Byte accesses are never misaligned.
- **Halt-drain FSM.** States RUN, DRAIN, HALTED, with a 2-bit drain counter cnt.
  - RUN: a capture edge with i_halt & i_valid (not stalled, not flushed) → DRAIN, cnt=0. The HALT itself is registered as a bubble apart from o_valid=1.
  - DRAIN: cnt increments every edge regardless of stall. When cnt=1, the next edge → HALTED. This gives the HALT two cycles to pass through MEM and WB.
  - HALTED: o_halted=1. Inputs are ignored and bubbles are loaded. The only exit is i_reset.
  - A flush while in DRAIN does not cancel the halt.
- Unused BHW codes are passed through unchanged; MEM decides what they mean.

## Timing
- All outputs are registered, with one-cycle latency from EX inputs to MEM outputs. MEM samples them during the same cycle (reads on the falling edge, writes on the next rising edge).
- Reset (asynchronous assert, takes effect immediately; release synchronous to i_clk):
  - every output is 0, including o_halted and o_misaligned;
  - FSM=RUN, cnt=0.
- o_misaligned is asserted for exactly the cycle(s) the offending slot is held. If stalled, it stays high until the slot leaves.
- o_halted rises 3 edges after the HALT capture edge and stays high.
- Stall and flush asserted together → bubble.
- i_halt presented during a stall is not accepted until the stall drops.
- Reset asserted mid-DRAIN → immediately RUN with o_halted=0.

## Test plan
- **Reset.** Assert i_reset between edges → all outputs 0 without waiting for an edge. Release, then present an LW at addr 0x10 → next edge: o_mem_read=1, o_mem_addr=0x10, o_BHW=011.
- **Store masking.** SB with rt=0xAABBCCDD → o_mem_data=0x000000DD. SH → 0x0000CCDD. SW → 0xAABBCCDD.
- **Misalignment.**
  - LH at addr 0x21 → o_misaligned=1, o_mem_read=0, o_reg_write=0.
  - SW at 0x22 → o_mem_write=0.
  - SB at 0x23 → normal, o_misaligned=0.
- **Stall/flush.**
  - Capture an ADD with rd=5, then stall 3 cycles while inputs change → outputs hold rd=5.
  - Stall and flush together → o_valid=0 next edge.
- **Halt drain.** HALT captured at edge N → FSM in DRAIN, o_halted=1 at edge N+3. Subsequent valid SW inputs produce o_mem_write=0.
- **Reset during DRAIN.** Reset mid-drain → o_halted stays 0, and the pipeline accepts new instructions after release.
